vx_rop_blend_arb: RTL and testbench

VX_ROP_BLEND_ARB -- requirements
Module: VX_rop_blend_arb

---
 rtl/vx_rop_blend_arb.sv | 268 ++++++++++++++++++++++++++
 tb/tb_vx_rop_blend_arb.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_rop_blend_arb.sv
// ============================================================================
// vx_rop_blend_arb
// ----------------------------------------------------------------------------
// Shares one blend unit among NUM_REQS requesters.
//   * Issue side: a round-robin arbiter picks one requester. A stalled transfer
//     locks the grant so the blend unit sees the same requester and data until
//     it accepts.
//   * Return side: responses are routed combinationally back to the requester
//     whose index is carried in the upper bits of the returned tag.
//   * A credit counter caps the number of outstanding transfers at
//     MAX_INFLIGHT.
//   * A RUN/DRAIN/ACK handshake empties the blend unit before a configuration
//     change. cfg_ack is high only once nothing is in flight.
//
// Ports
//   clk, reset                       clock, asynchronous active-low reset
//   req_valid/req_tag/req_*_color    per-requester issue request
//   req_ready                        per-requester issue accept
//   blend_valid_in/blend_tag_in/
//   blend_src_color/blend_dst_color  issue to the blend unit
//   blend_ready_in                   blend unit accept
//   blend_valid_out/blend_tag_out/
//   blend_color_out                  blend unit result
//   blend_ready_out                  result accept
//   rsp_valid/rsp_tag/rsp_color      per-requester response (tag/color shared)
//   rsp_ready                        per-requester response accept
//   cfg_req, cfg_ack                 drain request / drained acknowledge
//   inflight_count                   outstanding transfers
// ============================================================================

module vx_rop_blend_arb_chk #(
    parameter int CW           = 4,
    parameter int MAX_INFLIGHT = 8
) (
    input logic          clk,
    input logic          reset,
    input logic          rsp_fire,
    input logic [CW-1:0] inflight_count
);

    // A response that returns while nothing is outstanding is a protocol error.
    rsp_underflow_a: assert property (@(posedge clk) disable iff (!reset)
        !(rsp_fire && (inflight_count == '0)));

    // The credit counter must never pass its limit.
    count_bound_a: assert property (@(posedge clk) disable iff (!reset)
        inflight_count <= CW'(MAX_INFLIGHT));

endmodule

module vx_rop_blend_arb #(
    parameter int NUM_REQS     = 4,
    parameter int NUM_LANES    = 4,
    parameter int TAG_WIDTH    = 1,
    parameter int MAX_INFLIGHT = 8,
    localparam int RW          = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
    localparam int CW          = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_REQS-1:0]               req_valid,
    input  logic [NUM_REQS*TAG_WIDTH-1:0]     req_tag,
    input  logic [NUM_REQS*NUM_LANES*32-1:0]  req_src_color,
    input  logic [NUM_REQS*NUM_LANES*32-1:0]  req_dst_color,
    output logic [NUM_REQS-1:0]               req_ready,
    output logic                              blend_valid_in,
    output logic [RW+TAG_WIDTH-1:0]           blend_tag_in,
    output logic [NUM_LANES*32-1:0]           blend_src_color,
    output logic [NUM_LANES*32-1:0]           blend_dst_color,
    input  logic                              blend_ready_in,
    input  logic                              blend_valid_out,
    input  logic [RW+TAG_WIDTH-1:0]           blend_tag_out,
    input  logic [NUM_LANES*32-1:0]           blend_color_out,
    output logic                              blend_ready_out,
    output logic [NUM_REQS-1:0]               rsp_valid,
    output logic [TAG_WIDTH-1:0]              rsp_tag,
    output logic [NUM_LANES*32-1:0]           rsp_color,
    input  logic [NUM_REQS-1:0]               rsp_ready,
    input  logic                              cfg_req,
    output logic                              cfg_ack,
    output logic [CW-1:0]                     inflight_count
);

    localparam int DW = NUM_LANES * 32;
    localparam int TW = RW + TAG_WIDTH;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_INFLIGHT);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_ACK   = 2'd2
    } state_t;

    state_t          state_r;
    logic            cfg_ack_r;
    logic [RW-1:0]   rr_ptr_r;
    logic            lock_r;
    logic [RW-1:0]   lock_idx_r;
    logic [CW-1:0]   inflight_r;

    logic [RW-1:0]   rr_grant_s;
    logic            rr_found_s;
    logic [RW-1:0]   grant_s;
    logic            issue_valid_s;
    logic            issue_fire_s;
    logic            lock_nxt_s;
    logic [RW-1:0]   rsp_idx_s;
    logic            rsp_fire_s;
    logic [CW-1:0]   inflight_nxt_s;

    // (base + off) mod NUM_REQS; off is always below NUM_REQS+1 here.
    function automatic logic [RW-1:0] wrap_inc(input logic [RW-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_REQS) begin
            sum = sum - NUM_REQS;
        end else begin
            sum = sum;
        end
        return RW'(sum);
    endfunction

    // Round-robin search starting at rr_ptr_r, first valid requester wins.
    always_comb begin
        rr_grant_s = rr_ptr_r;
        rr_found_s = 1'b0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (!rr_found_s && req_valid[wrap_inc(rr_ptr_r, i)]) begin
                rr_found_s = 1'b1;
                rr_grant_s = wrap_inc(rr_ptr_r, i);
            end else begin
                rr_found_s = rr_found_s;
            end
        end
    end

    // Issue side: a pending locked transfer overrides arbitration and ignores
    // the credit/state gate, since it was already admitted when it first stalled.
    always_comb begin
        if (lock_r) begin
            grant_s = lock_idx_r;
        end else begin
            grant_s = rr_grant_s;
        end
        issue_valid_s = reset && (lock_r ||
                        ((state_r == ST_RUN) && (inflight_r < MAX_CNT) && rr_found_s));
        issue_fire_s  = issue_valid_s && blend_ready_in;
        lock_nxt_s    = issue_valid_s && !blend_ready_in;
        req_ready     = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            req_ready[i] = issue_fire_s && (grant_s == RW'(i));
        end
    end

    assign blend_valid_in  = issue_valid_s;
    assign blend_tag_in    = {grant_s, req_tag[grant_s*TAG_WIDTH +: TAG_WIDTH]};
    assign blend_src_color = req_src_color[grant_s*DW +: DW];
    assign blend_dst_color = req_dst_color[grant_s*DW +: DW];

    // Return side: route by the requester index carried in the tag.
    always_comb begin
        rsp_idx_s       = blend_tag_out[TW-1 -: RW];
        blend_ready_out = rsp_ready[rsp_idx_s];
        rsp_fire_s      = blend_valid_out && blend_ready_out;
        rsp_valid       = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            rsp_valid[i] = blend_valid_out && (rsp_idx_s == RW'(i));
        end
    end

    assign rsp_tag   = blend_tag_out[TAG_WIDTH-1:0];
    assign rsp_color = blend_color_out;

    // Credit counter next value, saturating at both ends.
    always_comb begin
        inflight_nxt_s = inflight_r;
        if (issue_fire_s && !rsp_fire_s) begin
            if (inflight_r < MAX_CNT) begin
                inflight_nxt_s = inflight_r + CW'(1);
            end else begin
                inflight_nxt_s = inflight_r;
            end
        end else if (!issue_fire_s && rsp_fire_s) begin
            if (inflight_r != '0) begin
                inflight_nxt_s = inflight_r - CW'(1);
            end else begin
                inflight_nxt_s = inflight_r;
            end
        end else begin
            inflight_nxt_s = inflight_r;
        end
    end

    // Arbitration pointer, grant lock and credit count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_r   <= '0;
            lock_r     <= 1'b0;
            lock_idx_r <= '0;
            inflight_r <= '0;
        end else begin
            if (issue_fire_s) begin
                rr_ptr_r <= wrap_inc(grant_s, 1);
            end else begin
                rr_ptr_r <= rr_ptr_r;
            end
            lock_r     <= lock_nxt_s;
            lock_idx_r <= grant_s;
            inflight_r <= inflight_nxt_s;
        end
    end

    // Drain FSM. The DRAIN exit looks at next-cycle values so cfg_ack rises in
    // the cycle right after the last outstanding response is accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_RUN;
            cfg_ack_r <= 1'b0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (cfg_req) begin
                        state_r <= ST_DRAIN;
                    end else begin
                        state_r <= ST_RUN;
                    end
                    cfg_ack_r <= 1'b0;
                end
                ST_DRAIN: begin
                    if ((inflight_nxt_s == '0) && !lock_nxt_s) begin
                        state_r   <= ST_ACK;
                        cfg_ack_r <= 1'b1;
                    end else begin
                        state_r   <= ST_DRAIN;
                        cfg_ack_r <= 1'b0;
                    end
                end
                ST_ACK: begin
                    if (!cfg_req) begin
                        state_r   <= ST_RUN;
                        cfg_ack_r <= 1'b0;
                    end else begin
                        state_r   <= ST_ACK;
                        cfg_ack_r <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= ST_RUN;
                    cfg_ack_r <= 1'b0;
                end
            endcase
        end
    end

    assign cfg_ack        = cfg_ack_r;
    assign inflight_count = inflight_r;

    vx_rop_blend_arb_chk #(
        .CW           (CW),
        .MAX_INFLIGHT (MAX_INFLIGHT)
    ) u_chk (
        .clk            (clk),
        .reset          (reset),
        .rsp_fire       (rsp_fire_s),
        .inflight_count (inflight_r)
    );

endmodule

// File: tb/tb_vx_rop_blend_arb.sv
// ============================================================================
// tb_vx_rop_blend_arb
// Directed bench: a table of per-cycle arbitration vectors followed by
// hand-written sequences for lock, credit limit, simultaneous fire, routing
// and drain. The bench plays the blend unit itself.
// ============================================================================

module tb_vx_rop_blend_arb;

    localparam int NR = 4;
    localparam int NL = 4;
    localparam int TG = 1;
    localparam int RW = 2;
    localparam int CW = 4;
    localparam int DW = NL * 32;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic [NR-1:0]       req_valid;
    logic [NR*TG-1:0]    req_tag;
    logic [NR*DW-1:0]    req_src_color;
    logic [NR*DW-1:0]    req_dst_color;
    logic [NR-1:0]       req_ready;
    logic                blend_valid_in;
    logic [RW+TG-1:0]    blend_tag_in;
    logic [DW-1:0]       blend_src_color;
    logic [DW-1:0]       blend_dst_color;
    logic                blend_ready_in;
    logic                blend_valid_out;
    logic [RW+TG-1:0]    blend_tag_out;
    logic [DW-1:0]       blend_color_out;
    logic                blend_ready_out;
    logic [NR-1:0]       rsp_valid;
    logic [TG-1:0]       rsp_tag;
    logic [DW-1:0]       rsp_color;
    logic [NR-1:0]       rsp_ready;
    logic                cfg_req;
    logic                cfg_ack;
    logic [CW-1:0]       inflight_count;

    int n_chk  = 0;
    int n_fail = 0;

    vx_rop_blend_arb dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_tag         (req_tag),
        .req_src_color   (req_src_color),
        .req_dst_color   (req_dst_color),
        .req_ready       (req_ready),
        .blend_valid_in  (blend_valid_in),
        .blend_tag_in    (blend_tag_in),
        .blend_src_color (blend_src_color),
        .blend_dst_color (blend_dst_color),
        .blend_ready_in  (blend_ready_in),
        .blend_valid_out (blend_valid_out),
        .blend_tag_out   (blend_tag_out),
        .blend_color_out (blend_color_out),
        .blend_ready_out (blend_ready_out),
        .rsp_valid       (rsp_valid),
        .rsp_tag         (rsp_tag),
        .rsp_color       (rsp_color),
        .rsp_ready       (rsp_ready),
        .cfg_req         (cfg_req),
        .cfg_ack         (cfg_ack),
        .inflight_count  (inflight_count)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [3:0] rv;
        logic       rdy;
        logic       ev;
        logic [1:0] eg;
        logic [3:0] err;
        logic [3:0] ecnt;
    } vec_t;

    vec_t tbl[10];

    function automatic logic [DW-1:0] color_of(input logic [3:0] kind, input int r);
        logic [DW-1:0] v;
        v = '0;
        for (int l = 0; l < NL; l++) begin
            v[l*32 +: 32] = {kind, 12'h000, 8'(r), 8'(l)};
        end
        return v;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        req_valid       = 4'b0000;
        blend_ready_in  = 1'b1;
        blend_valid_out = 1'b0;
        blend_tag_out   = 3'd0;
        blend_color_out = '0;
        rsp_ready       = 4'b1111;
        cfg_req         = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        idle();
        req_valid       = 4'b1111;
        blend_valid_out = 1'b1;
        blend_tag_out   = {2'd1, 1'b0};
        #1;
        chk("rst_valid",     DW'(blend_valid_in), DW'(1'b0));
        chk("rst_req_ready", DW'(req_ready),      DW'(4'b0000));
        chk("rst_cfg_ack",   DW'(cfg_ack),        DW'(1'b0));
        chk("rst_count",     DW'(inflight_count), DW'(4'd0));
        chk("rst_rsp_valid", DW'(rsp_valid),      DW'(4'b0010));
        @(negedge clk);
        idle();
        reset = 1'b1;
    endtask

    // Checks the issue side against an expected grant.
    task automatic chk_grant(input string name, input logic [1:0] g);
        chk({name, "_valid"}, DW'(blend_valid_in), DW'(1'b1));
        chk({name, "_tag"},   DW'(blend_tag_in),   DW'({g, req_tag[g]}));
        chk({name, "_src"},   blend_src_color,     color_of(4'hA, int'(g)));
        chk({name, "_dst"},   blend_dst_color,     color_of(4'hD, int'(g)));
    endtask

    initial begin
        int issues;
        req_tag = 4'b1010;
        for (int r = 0; r < NR; r++) begin
            req_src_color[r*DW +: DW] = color_of(4'hA, r);
            req_dst_color[r*DW +: DW] = color_of(4'hD, r);
        end
        idle();

        // Round-robin table: rr_ptr carries across rows; count before each edge.
        tbl[0] = '{4'b1111, 1'b1, 1'b1, 2'd0, 4'b0001, 4'd0};
        tbl[1] = '{4'b1111, 1'b1, 1'b1, 2'd1, 4'b0010, 4'd1};
        tbl[2] = '{4'b1111, 1'b1, 1'b1, 2'd2, 4'b0100, 4'd2};
        tbl[3] = '{4'b1111, 1'b1, 1'b1, 2'd3, 4'b1000, 4'd3};
        tbl[4] = '{4'b1111, 1'b1, 1'b1, 2'd0, 4'b0001, 4'd4};
        tbl[5] = '{4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 4'd5};
        tbl[6] = '{4'b1001, 1'b1, 1'b1, 2'd3, 4'b1000, 4'd5};
        tbl[7] = '{4'b0110, 1'b1, 1'b1, 2'd1, 4'b0010, 4'd6};
        tbl[8] = '{4'b0011, 1'b1, 1'b1, 2'd0, 4'b0001, 4'd7};
        tbl[9] = '{4'b1111, 1'b1, 1'b0, 2'd0, 4'b0000, 4'd8};

        do_reset();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            req_valid      = tbl[k].rv;
            blend_ready_in = tbl[k].rdy;
            #1;
            chk($sformatf("tbl%0d_valid", k), DW'(blend_valid_in), DW'(tbl[k].ev));
            chk($sformatf("tbl%0d_req_ready", k), DW'(req_ready), DW'(tbl[k].err));
            chk($sformatf("tbl%0d_count", k), DW'(inflight_count), DW'(tbl[k].ecnt));
            if (tbl[k].ev) begin
                chk_grant($sformatf("tbl%0d", k), tbl[k].eg);
            end
        end

        // Backpressure lock on requester 2 while requester 0 wakes up.
        do_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            req_valid      = (c == 0) ? 4'b0100 : 4'b0101;
            blend_ready_in = 1'b0;
            #1;
            chk_grant($sformatf("lock%0d", c), 2'd2);
            chk($sformatf("lock%0d_req_ready", c), DW'(req_ready), DW'(4'b0000));
        end
        @(negedge clk);
        blend_ready_in = 1'b1;
        #1;
        chk_grant("lock_accept", 2'd2);
        chk("lock_accept_req_ready", DW'(req_ready), DW'(4'b0100));
        @(negedge clk);
        req_valid = 4'b1111;
        #1;
        chk_grant("lock_next", 2'd3);
        chk("lock_next_count", DW'(inflight_count), DW'(4'd1));

        // Credit limit with responses held off, then one credit returned.
        do_reset();
        issues = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            req_valid = 4'b1111;
            #1;
            if (req_ready != 4'b0000) issues++;
        end
        chk("credit_issues", DW'(issues), DW'(8));
        chk("credit_valid", DW'(blend_valid_in), DW'(1'b0));
        chk("credit_count", DW'(inflight_count), DW'(4'd8));
        @(negedge clk);
        blend_valid_out = 1'b1;
        blend_tag_out   = {2'd0, 1'b0};
        #1;
        chk("credit_rsp_ready", DW'(blend_ready_out), DW'(1'b1));
        chk("credit_rsp_valid", DW'(blend_valid_in), DW'(1'b0));
        @(negedge clk);
        blend_valid_out = 1'b0;
        #1;
        chk("credit_after_rsp", DW'(inflight_count), DW'(4'd7));
        issues = 0;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (req_ready != 4'b0000) issues++;
        end
        chk("credit_extra", DW'(issues), DW'(1));
        chk("credit_refull", DW'(inflight_count), DW'(4'd8));

        // Issue and response in the same cycle at count 5.
        do_reset();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            req_valid = 4'b1111;
        end
        @(negedge clk);
        blend_valid_out = 1'b1;
        blend_tag_out   = {2'd0, 1'b0};
        #1;
        chk("sim_count_pre", DW'(inflight_count), DW'(4'd5));
        chk("sim_issue", DW'(req_ready != 4'b0000), DW'(1'b1));
        chk("sim_rsp", DW'(blend_ready_out), DW'(1'b1));
        @(negedge clk);
        idle();
        #1;
        chk("sim_count_post", DW'(inflight_count), DW'(4'd5));

        // Routing to requester 3 with its ready initially low.
        @(negedge clk);
        blend_valid_out = 1'b1;
        blend_tag_out   = {2'd3, 1'b1};
        blend_color_out = {32'h1122_3344, 32'h5566_7788, 32'h99AA_BBCC, 32'hDDEE_FF00};
        rsp_ready       = 4'b0111;
        #1;
        chk("route_rsp_valid", DW'(rsp_valid), DW'(4'b1000));
        chk("route_ready_low", DW'(blend_ready_out), DW'(1'b0));
        chk("route_tag", DW'(rsp_tag), DW'(1'b1));
        chk("route_color", rsp_color, {32'h1122_3344, 32'h5566_7788, 32'h99AA_BBCC, 32'hDDEE_FF00});
        @(negedge clk);
        rsp_ready = 4'b1111;
        #1;
        chk("route_hold_count", DW'(inflight_count), DW'(4'd5));
        chk("route_ready_high", DW'(blend_ready_out), DW'(1'b1));
        @(negedge clk);
        idle();
        #1;
        chk("route_dec_count", DW'(inflight_count), DW'(4'd4));

        // Drain with 3 transfers in flight.
        do_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            req_valid = 4'b1111;
        end
        @(negedge clk);
        req_valid = 4'b0000;
        cfg_req   = 1'b1;
        #1;
        chk("drain_count", DW'(inflight_count), DW'(4'd3));
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            req_valid       = 4'b1111;
            blend_valid_out = (c >= 2);
            blend_tag_out   = {2'(c), 1'b0};
            #1;
            chk($sformatf("drain%0d_valid", c), DW'(blend_valid_in), DW'(1'b0));
            chk($sformatf("drain%0d_ack", c), DW'(cfg_ack), DW'(1'b0));
        end
        @(negedge clk);
        blend_valid_out = 1'b0;
        #1;
        chk("drain_ack_rise", DW'(cfg_ack), DW'(1'b1));
        chk("drain_empty", DW'(inflight_count), DW'(4'd0));
        chk("drain_ack_valid", DW'(blend_valid_in), DW'(1'b0));
        @(negedge clk);
        cfg_req = 1'b0;
        #1;
        chk("drain_release_ack", DW'(cfg_ack), DW'(1'b1));
        chk("drain_release_valid", DW'(blend_valid_in), DW'(1'b0));
        @(negedge clk);
        #1;
        chk("drain_run_ack", DW'(cfg_ack), DW'(1'b0));
        chk("drain_run_valid", DW'(blend_valid_in), DW'(1'b1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
